// File: rtl/newton_refine_stage.sv
// newton_refine_stage: iterative Newton-Raphson refinement of a 1/sqrt(x) estimate.
// One arithmetic step per cycle (HALF, then SQ/MX/SUB/MY per pass). The arithmetic
// is truncating single precision. Special operands are flagged once in HALF, and the
// flagged value replaces the computed result at DONE, so latency is the same for
// every job.
//
// Handshake: a job transfers on a rising edge where in_valid & in_ready are both
// high. in_ready is high only in IDLE. A result transfers on a rising edge where
// out_valid & out_ready are both high. out_valid is high only in DONE, and
// y_out holds its value until that transfer.
module newton_refine_stage #(
    parameter int ITERATIONS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x_in,
    input  logic [31:0] y0_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y_out,
    output logic        busy,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HALF = 3'd1,
        SQ   = 3'd2,
        MX   = 3'd3,
        SUB  = 3'd4,
        MY   = 3'd5,
        DONE = 3'd6
    } state_e;

    localparam logic [1:0] LAST_PASS = 2'(ITERATIONS - 1);
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    state_e      state_q, state_d;
    logic [31:0] x_q, x_d;
    logic [31:0] y_q, y_d;
    logic [31:0] xh_q, xh_d;
    logic [31:0] s_q, s_d;
    logic [31:0] t_q, t_d;
    logic [31:0] r_q, r_d;
    logic [1:0]  pass_q, pass_d;
    logic        spec_q, spec_d;
    logic [31:0] spec_val_q, spec_val_d;

    // Truncating multiply. Zero/denormal operands give +0, underflow flushes to +0,
    // and overflow saturates to +inf.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [23:0] ma;
        logic [23:0] mb;
        logic [47:0] p;
        logic [22:0] frac;
        int          e;
        logic [31:0] res;
        ma = {1'b1, a[22:0]};
        mb = {1'b1, b[22:0]};
        p  = {24'd0, ma} * {24'd0, mb};
        e  = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            frac = p[46:24];
            e    = e + 1;
        end else begin
            frac = p[45:23];
        end
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || e <= 0) begin
            res = 32'd0;
        end else if (e >= 255) begin
            res = POS_INF;
        end else begin
            res = {a[31] ^ b[31], e[7:0], frac};
        end
        return res;
    endfunction

    // r = 1.5 - t for non-negative t. The smaller operand is aligned with three
    // guard bits, the result is left-normalized and truncated, and t >= 1.5 gives +0.
    function automatic logic [31:0] fsub15(input logic [31:0] t);
        logic [26:0] b;
        logic [26:0] d;
        logic [26:0] n;
        logic [7:0]  diff;
        logic [7:0]  e;
        logic [4:0]  lz;
        logic        found;
        logic [31:0] res;
        b     = 27'd0;
        d     = 27'd0;
        n     = 27'd0;
        diff  = 8'd0;
        e     = 8'd0;
        lz    = 5'd0;
        found = 1'b0;
        if (t[30:0] >= 31'h3FC0_0000) begin
            res = 32'd0;
        end else if (t[30:23] == 8'd0) begin
            res = 32'h3FC0_0000;
        end else begin
            diff = 8'd127 - t[30:23];
            b    = (diff > 8'd26) ? 27'd0 : ({1'b1, t[22:0], 3'b000} >> diff);
            d    = 27'h600_0000 - b;
            for (int i = 26; i >= 0; i--) begin
                if (!found) begin
                    if (d[i]) begin
                        found = 1'b1;
                    end else begin
                        lz = lz + 5'd1;
                    end
                end
            end
            n   = d << lz;
            e   = 8'd127 - {3'd0, lz};
            res = {1'b0, e, n[25:3]};
        end
        return res;
    endfunction

    // State and datapath registers; reset discards any job in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            x_q        <= 32'd0;
            y_q        <= 32'd0;
            xh_q       <= 32'd0;
            s_q        <= 32'd0;
            t_q        <= 32'd0;
            r_q        <= 32'd0;
            pass_q     <= 2'd0;
            spec_q     <= 1'b0;
            spec_val_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            xh_q       <= xh_d;
            s_q        <= s_d;
            t_q        <= t_d;
            r_q        <= r_d;
            pass_q     <= pass_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
        end
    end

    // Next-state, one datapath step per state, and handshake outputs.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        xh_d       = xh_q;
        s_d        = s_q;
        t_d        = t_q;
        r_d        = r_q;
        pass_d     = pass_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        y_out      = 32'd0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    x_d     = x_in;
                    y_d     = y0_in;
                    pass_d  = 2'd0;
                    state_d = HALF;
                end
            end
            HALF: begin
                // Halving by exponent decrement; the smallest normal halves to +0.
                xh_d = (x_q[30:23] == 8'd1) ? 32'd0
                                            : {x_q[31], x_q[30:23] - 8'd1, x_q[22:0]};
                spec_d     = 1'b1;
                spec_val_d = QNAN;
                if (y_q[30:23] == 8'd0 || y_q[30:23] == 8'hFF ||
                    (x_q[31] && x_q[30:0] != 31'd0) ||
                    (x_q[30:23] == 8'hFF && x_q[22:0] != 23'd0)) begin
                    spec_val_d = QNAN;
                end else if (x_q[30:23] == 8'd0) begin
                    spec_val_d = POS_INF;
                end else if (x_q[30:0] == 31'h7F80_0000) begin
                    spec_val_d = 32'd0;
                end else begin
                    spec_d = 1'b0;
                end
                state_d = SQ;
            end
            SQ: begin
                s_d     = fmul(y_q, y_q);
                state_d = MX;
            end
            MX: begin
                t_d     = fmul(xh_q, s_q);
                state_d = SUB;
            end
            SUB: begin
                r_d     = fsub15(t_q);
                state_d = MY;
            end
            MY: begin
                y_d = fmul(y_q, r_q);
                if (pass_q == LAST_PASS) begin
                    state_d = DONE;
                end else begin
                    pass_d  = pass_q + 2'd1;
                    state_d = SQ;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                y_out     = spec_q ? spec_val_q : y_q;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_newton_refine_stage.sv
// Directed bench for newton_refine_stage (ITERATIONS = 1). Expected values were
// worked out by hand using truncating single-precision arithmetic.
module tb_newton_refine_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x_in;
    logic [31:0] y0_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y_out;
    logic        busy;
    logic [2:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    // clock
    always #5 clk = ~clk;

    newton_refine_stage #(.ITERATIONS(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x_in       (x_in),
        .y0_in      (y0_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y_out      (y_out),
        .busy       (busy),
        .dbg_state_o(dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp_v);
        end
    endtask

    // Send one job and wait for its result. Call this task #1 after a rising edge.
    // If out_ready is high, the task also checks the result handshake.
    task automatic run_job(input string tag, input logic [31:0] x, input logic [31:0] y0,
                           input logic [31:0] exp_y);
        int lat;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        x_in     = x;
        y0_in    = y0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x_in     = 32'd0;
        y0_in    = 32'd0;
        lat      = 0;
        while (!out_valid && lat < 40) begin
            if (lat == 2) begin
                check({tag, "_busy"}, 32'(busy), 32'd1);
                check({tag, "_ready_busy"}, 32'(in_ready), 32'd0);
                check({tag, "_yout_idle"}, y_out, 32'd0);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd5);
        check({tag, "_y"}, y_out, exp_y);
        if (out_ready) begin
            @(posedge clk);
            #1;
            check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
            check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        logic seen_valid;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x_in      = 32'd0;
        y0_in     = 32'd0;

        // Reset state.
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_y_out", y_out, 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Main function.
        run_job("identity", 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        run_job("exact4", 32'h4080_0000, 32'h3F00_0000, 32'h3F00_0000);
        run_job("magic", 32'h3F00_0000, 32'h3FB7_59DF, 32'h3FB4_F95E);
        run_job("xh_flush", 32'h0080_0000, 32'h3F80_0000, 32'h3FC0_0000);
        run_job("t_ge_1p5", 32'h4080_0000, 32'h3F80_0000, 32'h0000_0000);

        // Special operands.
        run_job("sp_neg", 32'hBF80_0000, 32'h3F80_0000, 32'h7FC0_0000);
        run_job("sp_zero", 32'h0000_0000, 32'h3F80_0000, 32'h7F80_0000);
        run_job("sp_inf", 32'h7F80_0000, 32'h3F80_0000, 32'h0000_0000);
        run_job("sp_y0zero", 32'h3F80_0000, 32'h0000_0000, 32'h7FC0_0000);

        // Backpressure, with a stray job presented while the block is busy.
        out_ready = 1'b0;
        run_job("bp", 32'h4080_0000, 32'h3F00_0000, 32'h3F00_0000);
        in_valid = 1'b1;
        x_in     = 32'hBF80_0000;
        y0_in    = 32'h3F80_0000;
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_y", y_out, 32'h3F00_0000);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("bp_single_hs", 32'(out_valid), 32'd0);
        check("bp_stray_ignored", 32'(busy), 32'd0);

        // Reset in the middle of a job.
        x_in     = 32'h3F80_0000;
        y0_in    = 32'h3F80_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_y", y_out, 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid = 1'b1;
        end
        check("mid_rst_no_valid", 32'(seen_valid), 32'd0);
        run_job("post_rst", 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/newton_refine_stage.md
NEWTON_REFINE_STAGE -- requirements
Module: newton_refine_stage

Interface
REQ-001 SHALL have parameter ITERATIONS, default 1, number of Newton-Raphson refinement passes (legal 1..3).
REQ-002 SHALL have port clk, input, 1, single clock for all state; rising-edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, x_in/y0_in carry a job.
REQ-005 SHALL have port in_ready, output, 1, block can accept a job.
REQ-006 SHALL have port x_in, input, 32, IEEE-754 single operand x.
REQ-007 SHALL have port y0_in, input, 32, IEEE-754 single initial estimate of 1/sqrt(x), as produced by the upstream magic-constant stage.
REQ-008 SHALL have port out_valid, output, 1, y_out holds a result.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-010 SHALL have port y_out, output, 32, refined IEEE-754 single 1/sqrt(x).
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-012 SHALL compute y(n+1) = y(n) * (1.5 - xh * y(n) * y(n)), with xh = x/2 and y(0) = y0_in, repeated ITERATIONS times.
REQ-013 SHALL implement FSM states IDLE, HALF, SQ, MX, SUB, MY, DONE; each non-IDLE, non-DONE state lasts exactly 1 cycle.
REQ-014 SHALL transition IDLE->HALF on in_valid & in_ready, capturing x_in and y0_in into internal registers.
REQ-015 HALF: xh = x with biased exponent decremented by 1; if x exponent is 1, xh = +0.
REQ-016 SQ: s = y*y; MX: t = xh*s; SUB: r = 1.5 - t; MY: y = y*r.
REQ-017 After MY, SHALL go to SQ if passes remain, else to DONE.
REQ-018 Accept-to-out_valid latency SHALL be exactly 1 + 4*ITERATIONS cycles (5 for the default).
REQ-019 Multiply: 24x24-bit mantissa product with hidden bit, normalize by at most 1 bit, truncate (round toward zero), exponent = ea + eb - 127 (+1 on normalize).
REQ-020 Multiply: result exponent <= 0 SHALL flush to +0; exponent >= 255 SHALL saturate to +infinity (0x7F800000).
REQ-021 SUB: align the smaller operand with a 3-bit guard, subtract, left-normalize, truncate; t >= 1.5 SHALL yield r = +0.
REQ-022 Special inputs are detected in HALF and the computed result replaced at DONE; latency SHALL be unchanged.
REQ-023 Special x = +0 or denormal SHALL produce 0x7F800000.
REQ-024 Special x = +infinity SHALL produce 0x00000000.
REQ-025 Special x negative (sign=1, nonzero) or NaN SHALL produce 0x7FC00000.
REQ-026 y0_in exponent 0 or 255 SHALL produce 0x7FC00000.
REQ-027 in_ready SHALL be 1 only in IDLE; no job is accepted while busy.
REQ-028 DONE: out_valid = 1 and y_out stable until out_ready is sampled high.
REQ-029 DONE with out_ready = 1 SHALL go to IDLE next cycle; the next job may be accepted no earlier than that IDLE cycle (no bypass).
REQ-030 in_valid while busy SHALL be ignored without side effects.
REQ-031 y_out SHALL be 0x00000000 whenever out_valid = 0.

Reset
REQ-032 rst low SHALL immediately force state IDLE, in_ready = 1, out_valid = 0, busy = 0, y_out = 0x00000000, and clear all datapath registers.
REQ-033 rst asserted mid-computation or in DONE SHALL discard the job; no out_valid SHALL follow reset release.
REQ-034 After rst deasserts, the first job SHALL be accepted on the first rising edge with in_valid = 1.

Verification
REQ-035 Identity: x = 0x3F800000, y0 = 0x3F800000, out_ready = 1 -> out_valid exactly 5 cycles after accept, y_out = 0x3F800000.
REQ-036 Exact case: x = 0x40800000 (4.0), y0 = 0x3F000000 (0.5) -> y_out = 0x3F000000.
REQ-037 Magic-estimate chain: x = 0x3F000000, y0 = 0x3FB759DF -> y_out in [0x3FB4F900, 0x3FB4FA00]; must match bit-exact truncating software model.
REQ-038 Backpressure: out_ready = 0 for 10 cycles in DONE -> out_valid and y_out stable, in_ready = 0 throughout, single handshake on release.
REQ-039 Specials: x = 0xBF800000 -> 0x7FC00000; x = 0x00000000 -> 0x7F800000; x = 0x7F800000 -> 0x00000000; each after 5 cycles.
REQ-040 Reset mid-op: rst low in cycle 3 after accept -> outputs at reset values immediately, no out_valid afterwards; a subsequent identity job returns 0x3F800000.
